// File: rtl/fb_pkg.sv
// Shared types and constants for the Flappy Bird frame-synchronous register controller.
package fb_pkg;

  localparam logic [9:0]  VACTIVE = 10'd480;
  localparam logic [10:0] HTOTAL  = 11'd1600;

  localparam logic [3:0] ADDR_BIRD_LO = 4'd0;
  localparam logic [3:0] ADDR_BIRD_HI = 4'd1;
  localparam logic [3:0] ADDR_PIPE_LO = 4'd2;
  localparam logic [3:0] ADDR_PIPE_HI = 4'd3;
  localparam logic [3:0] ADDR_GAP_LO  = 4'd4;
  localparam logic [3:0] ADDR_GAP_HI  = 4'd5;
  localparam logic [3:0] ADDR_CTRL    = 4'd6;
  localparam logic [3:0] ADDR_STATUS  = 4'd7;
  localparam logic [3:0] ADDR_FRAME   = 4'd8;

  localparam int CTRL_ARM     = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_IRQ_CLR = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic [9:0]  bird_y;
    logic [10:0] pipe_x;
    logic [9:0]  gap_y;
  } fb_pos_t;

  // First pixel of the first blanking line: one cycle per frame.
  function automatic logic is_vb(input logic [10:0] hcount, input logic [9:0] vcount);
    return (vcount == VACTIVE) && (hcount == 11'd0);
  endfunction

endpackage

// File: rtl/fb_frame_ctrl_if.sv
// Avalon-MM slave bus between the HPS bridge and the frame controller.
// Transfer rules: a write is accepted on any edge sampling chipselect && write (no
// waitrequest); a read sampled with chipselect && read returns readdata one cycle later.
interface fb_frame_ctrl_if;
  logic       chipselect;
  logic       write;
  logic       read;
  logic [3:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );
endinterface

// File: rtl/fb_regfile.sv
// Shadow/active position registers: byte-wide shadow writes, single-cycle copy on load.
module fb_regfile
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  input  logic       load,
  output fb_pos_t    shadow,
  output fb_pos_t    active
);

  fb_pos_t shadow_nxt;

  always_comb begin
    shadow_nxt = shadow;
    if (we) begin
      case (addr)
        ADDR_BIRD_LO: shadow_nxt.bird_y[7:0]  = wdata;
        ADDR_BIRD_HI: shadow_nxt.bird_y[9:8]  = wdata[1:0];
        ADDR_PIPE_LO: shadow_nxt.pipe_x[7:0]  = wdata;
        ADDR_PIPE_HI: shadow_nxt.pipe_x[10:8] = wdata[2:0];
        ADDR_GAP_LO:  shadow_nxt.gap_y[7:0]   = wdata;
        ADDR_GAP_HI:  shadow_nxt.gap_y[9:8]   = wdata[1:0];
        default: ;
      endcase
    end
  end

  // Active copies the post-write shadow so a write on the load cycle is part of the commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      shadow <= shadow_nxt;
      if (load) active <= shadow_nxt;
    end
  end

endmodule

// File: rtl/fb_frame_ctrl.sv
// Frame-synchronous commit controller: arm FSM, frame counter, commit irq and register readback.
module fb_frame_ctrl
  import fb_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  fb_frame_ctrl_if.slave      bus,
  input  logic [10:0]         hcount,
  input  logic [9:0]          vcount,
  output logic [9:0]          bird_y,
  output logic [10:0]         pipe_x,
  output logic [9:0]          gap_y,
  output logic [7:0]          frame_cnt,
  output logic                irq,
  output ctrl_state_t         dbg_state
);

  ctrl_state_t state_q, state_d;
  fb_pos_t     shadow, active;
  logic        vb, wr, rd, ctrl_wr, arm_wr, clr_wr;
  logic        load, in_commit, armed;
  logic        irq_en, irq_set;
  logic [7:0]  rd_mux;

  assign vb      = is_vb(hcount, vcount);
  assign wr      = bus.chipselect && bus.write;
  assign rd      = bus.chipselect && bus.read;
  assign ctrl_wr = wr && (bus.address == ADDR_CTRL);
  assign arm_wr  = ctrl_wr && bus.writedata[CTRL_ARM];
  assign clr_wr  = ctrl_wr && bus.writedata[CTRL_IRQ_CLR];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm_wr) state_d = ARMED;
      ARMED:   if (vb)     state_d = COMMIT;
      COMMIT:  state_d = arm_wr ? ARMED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load      = (state_q == ARMED) && vb;
    in_commit = (state_q == COMMIT);
    armed     = (state_q == ARMED);
  end

  fb_regfile u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr),
    .addr    (bus.address),
    .wdata   (bus.writedata),
    .load    (load),
    .shadow  (shadow),
    .active  (active)
  );

  // irq rises with the active copy and is held through COMMIT so a clear in that cycle loses.
  assign irq_set = irq_en && (load || in_commit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en    <= 1'b0;
      irq       <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      if (ctrl_wr) irq_en <= bus.writedata[CTRL_IRQ_EN];
      if (irq_set)     irq <= 1'b1;
      else if (clr_wr) irq <= 1'b0;
      if (vb) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    rd_mux = 8'd0;
    case (bus.address)
      ADDR_BIRD_LO: rd_mux = shadow.bird_y[7:0];
      ADDR_BIRD_HI: rd_mux = {6'd0, shadow.bird_y[9:8]};
      ADDR_PIPE_LO: rd_mux = shadow.pipe_x[7:0];
      ADDR_PIPE_HI: rd_mux = {5'd0, shadow.pipe_x[10:8]};
      ADDR_GAP_LO:  rd_mux = shadow.gap_y[7:0];
      ADDR_GAP_HI:  rd_mux = {6'd0, shadow.gap_y[9:8]};
      ADDR_STATUS:  rd_mux = {5'd0, irq_en, irq, armed};
      ADDR_FRAME:   rd_mux = frame_cnt;
      default:      rd_mux = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  bus.readdata <= 8'd0;
    else if (rd)   bus.readdata <= rd_mux;
  end

  assign bird_y    = active.bird_y;
  assign pipe_x    = active.pipe_x;
  assign gap_y     = active.gap_y;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fb_frame_ctrl.sv
// Directed bench for fb_frame_ctrl: register table plus hand-written commit/irq/frame sequences.
module tb_fb_frame_ctrl;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [9:0]  bird_y;
  logic [10:0] pipe_x;
  logic [9:0]  gap_y;
  logic [7:0]  frame_cnt;
  logic        irq;
  ctrl_state_t dbg_state;

  fb_frame_ctrl_if bus();

  fb_frame_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .hcount    (hcount),
    .vcount    (vcount),
    .bird_y    (bird_y),
    .pipe_x    (pipe_x),
    .gap_y     (gap_y),
    .frame_cnt (frame_cnt),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // ---- clock / reset ----
  always #10 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } rw_vec_t;

  rw_vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // ---- driver tasks ----
  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic bus_read_check(input logic [3:0] a, input logic [7:0] want, input string name);
    exp_q.push_back({24'd0, want});
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    tick();
    bus_idle();
    check(name, {24'd0, bus.readdata}, exp_q.pop_front());
  endtask

  task automatic pulse_vb();
    vcount = VACTIVE;
    hcount = 11'd0;
    tick();
    vcount = 10'd0;
    hcount = 11'd1;
  endtask

  // Bus write landing on the same edge that samples the vblank strobe.
  task automatic vb_with_write(input logic [3:0] a, input logic [7:0] d);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    vcount         = VACTIVE;
    hcount         = 11'd0;
    tick();
    bus_idle();
    vcount = 10'd0;
    hcount = 11'd1;
  endtask

  task automatic check_active(input string tag, input logic [9:0] b, input logic [10:0] p,
                              input logic [9:0] g);
    check({tag, "_bird"}, {22'd0, bird_y}, {22'd0, b});
    check({tag, "_pipe"}, {21'd0, pipe_x}, {21'd0, p});
    check({tag, "_gap"},  {22'd0, gap_y},  {22'd0, g});
  endtask

  task automatic write_pos(input logic [9:0] b, input logic [10:0] p, input logic [9:0] g);
    bus_write(ADDR_BIRD_LO, b[7:0]);
    bus_write(ADDR_BIRD_HI, {6'd0, b[9:8]});
    bus_write(ADDR_PIPE_LO, p[7:0]);
    bus_write(ADDR_PIPE_HI, {5'd0, p[10:8]});
    bus_write(ADDR_GAP_LO,  g[7:0]);
    bus_write(ADDR_GAP_HI,  {6'd0, g[9:8]});
  endtask

  initial begin
    bus_idle();
    bus.address   = 4'd0;
    bus.writedata = 8'd0;
    hcount        = 11'd1;
    vcount        = 10'd0;
    do_reset();

    // ---- reset state ----
    check_active("rst", 10'd0, 11'd0, 10'd0);
    check("rst_frame", {24'd0, frame_cnt}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", {24'd0, bus.readdata}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // ---- reset while ARMED cancels the pending commit ----
    write_pos(10'h12C, 11'h4B0, 10'h0F0);
    bus_write(ADDR_CTRL, 8'h03);
    bus_read_check(ADDR_STATUS, 8'h05, "pre_rst_status");
    reset_n = 1'b0;
    tick();
    check("in_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    reset_n = 1'b1;
    tick();
    check("midrst_readdata", {24'd0, bus.readdata}, 32'd0);
    bus_read_check(ADDR_STATUS, 8'h00, "midrst_status");
    bus_read_check(ADDR_BIRD_LO, 8'h00, "midrst_shadow");
    pulse_vb();
    check_active("midrst_vb", 10'd0, 11'd0, 10'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_frame", {24'd0, frame_cnt}, 32'd1);

    // ---- table: shadow byte writes and readback masks ----
    vecs[0]  = '{ADDR_BIRD_LO, 8'hA5, 8'hA5};
    vecs[1]  = '{ADDR_BIRD_HI, 8'hFF, 8'h03};
    vecs[2]  = '{ADDR_PIPE_LO, 8'h3C, 8'h3C};
    vecs[3]  = '{ADDR_PIPE_HI, 8'hFF, 8'h07};
    vecs[4]  = '{ADDR_GAP_LO,  8'hC3, 8'hC3};
    vecs[5]  = '{ADDR_GAP_HI,  8'hFE, 8'h02};
    for (int i = 0; i < 7; i++) vecs[6 + i] = '{4'(9 + i), 8'hFF, 8'h00};
    for (int i = 0; i < 13; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read_check(vecs[i].addr, vecs[i].exp_rd, $sformatf("regfile_rb_a%0d", vecs[i].addr));
    end
    check_active("no_arm", 10'd0, 11'd0, 10'd0);
    bus_read_check(ADDR_FRAME, 8'h01, "frame_rb");

    // ---- basic commit ----
    write_pos(10'h12C, 11'h4B0, 10'h0F0);
    bus_write(ADDR_CTRL, 8'h01);
    bus_read_check(ADDR_STATUS, 8'h01, "armed_status");
    repeat (5) tick();
    check_active("pre_vb", 10'd0, 11'd0, 10'd0);
    pulse_vb();
    check_active("commit", 10'd300, 11'd1200, 10'd240);
    check("commit_state", {30'd0, dbg_state}, {30'd0, COMMIT});
    check("commit_irq_off", {31'd0, irq}, 32'd0);
    tick();
    check("post_commit_state", {30'd0, dbg_state}, {30'd0, IDLE});
    bus_read_check(ADDR_STATUS, 8'h00, "disarmed_status");

    // ---- late write on vb is committed; write during COMMIT is not ----
    bus_write(ADDR_CTRL, 8'h01);
    vb_with_write(ADDR_BIRD_LO, 8'h55);
    check("late_bird", {22'd0, bird_y}, 32'h155);
    bus_write(ADDR_GAP_LO, 8'h11);
    check("commit_gap_held", {22'd0, gap_y}, 32'd240);
    pulse_vb();
    check_active("unarmed_vb", 10'h155, 11'd1200, 10'd240);
    bus_write(ADDR_CTRL, 8'h01);
    pulse_vb();
    check_active("next_commit", 10'h155, 11'd1200, 10'h011);

    // ---- arm coinciding with vb waits for the next frame ----
    bus_write(ADDR_BIRD_LO, 8'h01);
    vb_with_write(ADDR_CTRL, 8'h01);
    check("arm_on_vb_bird", {22'd0, bird_y}, 32'h155);
    check("arm_on_vb_state", {30'd0, dbg_state}, {30'd0, ARMED});
    repeat (3) tick();
    pulse_vb();
    check("arm_on_vb_commit", {22'd0, bird_y}, 32'h101);

    // ---- re-arm during COMMIT is kept ----
    bus_write(ADDR_CTRL, 8'h01);
    pulse_vb();
    bus_write(ADDR_CTRL, 8'h01);
    check("rearm_state", {30'd0, dbg_state}, {30'd0, ARMED});
    pulse_vb();
    tick();

    // ---- irq set / clear priority ----
    bus_write(ADDR_CTRL, 8'h03);
    bus_read_check(ADDR_STATUS, 8'h05, "irq_armed_status");
    check("irq_pre", {31'd0, irq}, 32'd0);
    pulse_vb();
    check("irq_rise", {31'd0, irq}, 32'd1);
    bus_write(ADDR_CTRL, 8'h06);
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    bus_write(ADDR_CTRL, 8'h00);
    check("irq_en_off_keeps", {31'd0, irq}, 32'd1);
    bus_read_check(ADDR_STATUS, 8'h02, "irq_pending_status");
    bus_write(ADDR_CTRL, 8'h04);
    check("irq_clr", {31'd0, irq}, 32'd0);
    bus_write(ADDR_CTRL, 8'h01);
    pulse_vb();
    tick();
    check("irq_disabled_commit", {31'd0, irq}, 32'd0);
    bus_read_check(ADDR_STATUS, 8'h00, "irq_final_status");

    // ---- frame counter wrap without arming ----
    do_reset();
    for (int i = 0; i < 256; i++) begin
      pulse_vb();
      tick();
    end
    check("frame_wrap", {24'd0, frame_cnt}, 32'd0);
    pulse_vb();
    check("frame_257", {24'd0, frame_cnt}, 32'd1);
    bus_read_check(ADDR_FRAME, 8'h01, "frame_257_rb");
    check_active("frames_idle", 10'd0, 11'd0, 10'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_frame_ctrl.md
# fb_frame_ctrl

Frame-synchronous register controller between the HPS Avalon bus and the Flappy Bird VGA renderer. Software writes bird/pipe/gap positions into shadow registers at any time and arms a commit; the block copies all shadows into the active registers in one cycle at the start of vertical blanking. The renderer therefore never sees a half-updated frame. The block also counts frames and raises an interrupt per commit.

## Interface
- No parameters. Constants `VACTIVE` = 480 and `HTOTAL` = 1600 live in the package.
- `clk` in 1: 50 MHz system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `chipselect` in 1: Avalon select.
- `write` in 1: Avalon write strobe.
- `read` in 1: Avalon read strobe.
- `address` in 4: register index.
- `writedata` in 8: write byte.
- `readdata` out 8: read byte, registered.
- `hcount` in 11: from vga_counters.
- `vcount` in 10: from vga_counters.
- `bird_y` out 10: active bird row.
- `pipe_x` out 11: active pipe column, in hcount units.
- `gap_y` out 10: active gap top row.
- `frame_cnt` out 8: frames since reset, wraps.
- `irq` out 1: commit-done interrupt, level.

## Operation
- Register map (R = read, W = write):
  - 0: BIRD_LO, RW.
  - 1: BIRD_HI, RW, bits [1:0].
  - 2: PIPE_LO, RW.
  - 3: PIPE_HI, RW, bits [2:0].
  - 4: GAP_LO, RW.
  - 5: GAP_HI, RW, bits [1:0].
  - 6: CTRL, W. Bit0 arm, bit1 irq_en (stored), bit2 irq_clr.
  - 7: STATUS, R. Bit0 armed, bit1 irq, bit2 irq_en.
  - 8: FRAME, R.
  - 9–15: read 0, writes ignored.
- Unused high bits of HI registers read 0.
- Reads of 0–5 return the shadow value, not the active value.
- Shadow writes are accepted in every state; the last value written before the commit cycle wins.
- vblank strobe `vb` = (vcount == VACTIVE) && (hcount == 0). It is one cycle per frame.
- FSM states:
  - IDLE: a CTRL write with arm=1 goes to ARMED.
  - ARMED: `vb` goes to COMMIT. A re-arm while ARMED is a no-op.
  - COMMIT: lasts one cycle. The active registers are loaded from the shadows on entry to COMMIT, i.e. at the clock edge after `vb`. Next state is IDLE.
    - If an arm write arrives during COMMIT, next state is ARMED (the request is kept).
- Same cycle as `vb`:
  - An arm write in IDLE goes to ARMED only. The commit waits for the next frame.
  - A shadow write in ARMED lands in the shadow and is included in this commit, because the copy happens one edge later.
- frame_cnt increments on every `vb`, 8-bit wrap from 255 to 0. It is independent of the FSM.
- irq:
  - Set on the COMMIT cycle when irq_en=1.
  - Cleared by a CTRL write with irq_clr=1.
  - If set and clear occur in the same cycle, set wins.
  - Clearing irq_en does not clear a pending irq.
- reset_n low, at any time including mid-ARMED: FSM goes to IDLE and all shadow, active, irq_en, irq, frame_cnt and readdata registers go to 0. No commit occurs.

## Timing
- Read latency 1: readdata is valid the cycle after `chipselect && read`. Otherwise readdata holds its last value.
- Write takes effect at the clock edge where `chipselect && write` is sampled.
- Active outputs update 1 cycle after `vb`, which is well inside vblank: about 45 lines of margin before row 0.
- irq asserts on the same edge the active outputs update.
- STATUS.armed drops on that same edge.
- Commit worst-case latency from an arm write: 1 frame + 1 cycle = 840 001 clk.
- All outputs are registered. No combinational path from the bus to the renderer outputs.

## Structure
- Package `fb_pkg`:
  - `typedef enum logic [1:0] {IDLE, ARMED, COMMIT} ctrl_state_t`.
  - Register address localparams.
  - `VACTIVE`, `HTOTAL`.
  - `typedef struct packed` `fb_pos_t` {bird_y, pipe_x, gap_y}, used for both shadow and active.
- One sub-module: `fb_regfile`. It holds the shadow and active `fb_pos_t`, the byte write decode, and the `load` input.
- The top level holds the FSM, frame counter, irq and readback mux.

## Test plan
- Reset: hold reset_n low mid-ARMED, release. All outputs are 0, STATUS = 0, and no commit occurs on the next `vb`.
- Basic commit:
  - Write BIRD = 0x12C, PIPE = 0x4B0, GAP = 0x0F0, then arm.
  - Active outputs stay unchanged until `vb`. At `vb`+1 they read 300, 1200, 240.
  - STATUS.armed goes 1 → 0.
- Late write:
  - While ARMED, write BIRD_LO = 0x55 on the `vb` cycle. It commits: bird_y[7:0] = 0x55.
  - Write GAP at `vb`+1 (during COMMIT). It is not committed; active gap is unchanged until the next armed frame.
- Arm on `vb`: an arm write in IDLE coinciding with `vb` gives no update this frame and a commit at the next `vb`.
- irq:
  - irq_en = 1, commit. irq rises at `vb`+1.
  - Write irq_clr on that same cycle: irq stays 1 (set wins). A clear on the next cycle gives irq = 0.
  - irq_en = 0 commit: irq stays 0.
- frame_cnt: run 257 frames without arming. FRAME reads 1 and the active outputs are unchanged.
